// File: rtl/servo_pose_sequencer.sv
// servo_pose_sequencer: pose-table driven multi-channel servo PWM with rate-limited slewing
module servo_pose_sequencer #(
  parameter int N_CH = 5,
  parameter int N_POSES = 16,
  parameter int CLK_HZ = 50_000_000,
  parameter int FRAME_US = 20000,
  parameter int MIN_US = 500,
  parameter int MAX_US = 2500,
  parameter int RESET_US = 1500,
  parameter int STEP_US = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic pose_wr_en,
  input  logic [$clog2(N_POSES)-1:0] pose_wr_addr,
  input  logic [$clog2(N_CH)-1:0] pose_wr_ch,
  input  logic [15:0] pose_wr_data,
  input  logic gesture_valid,
  input  logic [7:0] gesture,
  output logic gesture_ready,
  output logic busy,
  output logic frame_tick,
  output logic [N_CH-1:0] pwm_out
);
  localparam int PRE = CLK_HZ / 1_000_000;
  localparam int PW = $clog2(PRE);
  localparam int UW = $clog2(FRAME_US);
  localparam int AW = $clog2(N_POSES);
  typedef enum logic {IDLE, MOVE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d;
  logic [15:0] cur_q [N_CH];
  logic [15:0] cur_d [N_CH];
  logic [15:0] tgt_q [N_CH];
  logic [15:0] tgt_d [N_CH];
  logic [15:0] tbl_q [N_POSES][N_CH];
  logic [15:0] tbl_d [N_POSES][N_CH];
  logic [N_CH-1:0] pwm_q, pwm_d;
  logic ready_q, ready_d, busy_q, busy_d;
  logic bnd, settled;
  logic [15:0] wr_val;
  logic [AW-1:0] row;
  function automatic logic [15:0] slew(input logic [15:0] c, input logic [15:0] t);
    logic [15:0] d;
    d = c < t ? t - c : c - t;
    d = d > 16'(STEP_US) ? 16'(STEP_US) : d;
    return c < t ? c + d : c - d;
  endfunction
  // frame boundary is the cycle both counters sit at zero; held low while in reset
  assign bnd = pre_q == '0 && us_q == '0;
  assign frame_tick = bnd && reset;
  assign gesture_ready = ready_q;
  assign busy = busy_q;
  assign pwm_out = pwm_q;
  // 1 us prescaler and in-frame microsecond counter
  always_comb begin
    pre_d = pre_q == PW'(PRE - 1) ? '0 : pre_q + PW'(1);
    us_d = pre_q != PW'(PRE - 1) ? us_q : us_q == UW'(FRAME_US - 1) ? '0 : us_q + UW'(1);
  end
  // pose table: clamped single-entry writes, out-of-range rows or channels dropped
  always_comb begin
    wr_val = pose_wr_data < 16'(MIN_US) ? 16'(MIN_US) : pose_wr_data > 16'(MAX_US) ? 16'(MAX_US) : pose_wr_data;
    tbl_d = tbl_q;
    if (pose_wr_en && 32'(pose_wr_addr) < N_POSES && 32'(pose_wr_ch) < N_CH) tbl_d[pose_wr_addr][pose_wr_ch] = wr_val;
  end
  // gesture accept loads targets from the pre-write table; moves step once per frame boundary
  always_comb begin
    row = gesture[AW-1:0];
    state_d = state_q;
    tgt_d = tgt_q;
    cur_d = cur_q;
    settled = 1'b1;
    if (state_q == IDLE && gesture_valid && gesture != 8'd0 && 32'(gesture) < N_POSES) begin
      tgt_d = tbl_q[row];
      state_d = MOVE;
    end
    if (state_q == MOVE && bnd) begin
      for (int i = 0; i < N_CH; i++) begin
        cur_d[i] = slew(cur_q[i], tgt_q[i]);
        settled = settled && cur_d[i] == tgt_q[i];
      end
      state_d = settled ? IDLE : MOVE;
    end
    ready_d = state_d == IDLE;
    busy_d = state_d == MOVE;
    for (int i = 0; i < N_CH; i++) pwm_d[i] = 16'(us_q) < cur_d[i];
  end
  // all state, including the pose table, clears asynchronously when reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      us_q <= '0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      pwm_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i] <= 16'(RESET_US);
        tgt_q[i] <= 16'(RESET_US);
      end
      for (int p = 0; p < N_POSES; p++)
        for (int i = 0; i < N_CH; i++) tbl_q[p][i] <= 16'(RESET_US);
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      us_q <= us_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      pwm_q <= pwm_d;
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      tbl_q <= tbl_d;
    end
  end
endmodule
